sad_pipe_stage: RTL and testbench
=================================

# sad_pipe_stage

Parametrised elastic pipeline register between SAD datapath stages, generalising the fixed 8-lane, 14-bit SAD2→SAD3 register. It carries NUM_LANES result lanes plus the block index and trigger sideband. A valid/ready handshake with a two-entry skid buffer lets a downstream stall back-pressure the upstream stage without losing data. It also supports synchronous flush and keeps a saturating stall-cycle counter for performance debug.

## Interface

- NUM_LANES, default 8: number of data lanes.
- DATA_W, default 14: width of each lane in bits.
- INDEX_W, default 16: width of the block index sideband.
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous reset, active-high.
- flush  input  1  synchronous flush; discards all held entries.
- in_valid  input  1  upstream entry present.
- in_ready  output  1  stage can accept an entry this cycle.
- in_data  input  NUM_LANES*DATA_W  lanes packed; lane k at bits [k*DATA_W +: DATA_W].
- in_index  input  INDEX_W  block index of the entry.
- in_trigger  input  1  trigger flag of the entry.
- out_valid  output  1  entry presented downstream.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  NUM_LANES*DATA_W  lanes, same packing as in_data.
- out_index  output  INDEX_W  index of the presented entry.
- out_trigger  output  1  trigger of the presented entry.
- stall_count  output  16  saturating count of cycles with out_valid=1 and out_ready=0.

## Operation

- Storage: main register (drives the out_* ports) and skid register. Each has a valid bit; an entry is {data, index, trigger}.
- Transfers:
  - Accept: in_valid & in_ready.
  - Emit: out_valid & out_ready.
- in_ready = ~skid_valid. It depends only on state, with no combinational path from out_ready.
- out_valid = main_valid.
- States:
  - EMPTY: neither register valid.
  - HALF: main valid only.
  - FULL: main and skid both valid.
- Transitions (priority: rst > flush > normal):
  - EMPTY + accept → HALF; the incoming entry loads main.
  - HALF + accept + emit → HALF; the incoming entry loads main.
  - HALF + accept, no emit → FULL; the incoming entry loads skid.
  - HALF + emit, no accept → EMPTY.
  - FULL + emit → HALF; skid moves to main. No accept is possible in FULL because in_ready=0.
  - All other combinations hold state.
- flush (rst low):
  - Clears main_valid and skid_valid next cycle, giving state EMPTY.
  - Any accept in the flush cycle is discarded.
  - An emit in the flush cycle still counts as consumed by downstream.
  - Data, index and trigger registers hold their values.
  - stall_count is unaffected.
- rst: all valid bits cleared, all data/index/trigger registers set to 0, stall_count set to 0.
- stall_count:
  - Increments by 1 in any cycle where out_valid=1, out_ready=0 and rst=0.
  - Saturates at 16'hFFFF and does not wrap.
  - Cleared only by rst.
- Ordering: entries leave in exactly the order accepted. No entry is duplicated or dropped except by flush or rst.
- Lanes are passed through bit-exact. No arithmetic is performed on data.

## Timing

- Reset values (the cycle after rst is sampled high):
  - out_valid=0, out_data=0, out_index=0, out_trigger=0, stall_count=0.
  - in_ready=1.
- Latency: an entry accepted at edge N appears on out_* at edge N (registered), i.e. one cycle from in_* to out_*. This matches the fixed single-register stage it replaces.
- Throughput: one entry per cycle while out_ready=1.
- Back-pressure:
  - After out_ready deasserts, at most one further entry is accepted (into skid).
  - in_ready falls the cycle after that.
  - in_ready rises the cycle after the first emit from FULL.
- Simultaneous events:
  - rst with flush, accept or emit: rst wins.
  - flush with accept: the entry is dropped.
  - In HALF, accept with emit: passes through main with no bubble.
- rst mid-stream: all in-flight entries are lost, with no partial emit afterwards.

## Test plan

- Streaming: out_ready=1; send indices 0..15 back-to-back with lane k = index+k.
  - Required: out_valid 1 cycle later, indices 0..15 in order, lane data exact, in_ready stays 1, stall_count=0.
- Stall and skid:
  - Stimulus: send indices 1,2,3 on consecutive cycles; drop out_ready the cycle index 1 is presented; hold it low 4 cycles, then raise it.
  - Required: index 2 is held in skid, in_ready=0 while FULL, index 3 is held upstream, output sequence is 1,2,3 with none lost, stall_count=4.
- Flush in FULL: reach FULL (indices 5,6), then pulse flush while in_valid=1 with index 7.
  - Required: next cycle out_valid=0 and in_ready=1; index 7 is never emitted; stall_count is unchanged.
- Reset mid-operation: in FULL with stall_count=10, assert rst for 1 cycle with in_valid=1.
  - Required: next cycle out_valid=0, out_data/out_index/out_trigger=0, stall_count=0, in_ready=1.
- Saturation: hold out_valid=1 and out_ready=0 for 65540 cycles.
  - Required: stall_count reaches 16'hFFFF and stays there.
- Parameter sweep: repeat the streaming test with NUM_LANES=1/DATA_W=8 and NUM_LANES=16/DATA_W=20.
  - Required: the trigger pattern 1,0,1,1 is preserved per entry and the lane packing is correct.

Source files
------------

// File: rtl/sad_pipe_stage.sv
// Elastic pipeline register between SAD datapath stages: a main register plus a skid
// register carrying NUM_LANES result lanes with index/trigger sideband.
module sad_pipe_stage #(
  parameter int unsigned NUM_LANES = 8,
  parameter int unsigned DATA_W    = 14,
  parameter int unsigned INDEX_W   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_LANES*DATA_W-1:0]   in_data,
  input  logic [INDEX_W-1:0]            in_index,
  input  logic                          in_trigger,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_LANES*DATA_W-1:0]   out_data,
  output logic [INDEX_W-1:0]            out_index,
  output logic                          out_trigger,
  output logic [15:0]                   stall_count
);

  localparam int unsigned BUS_W = NUM_LANES * DATA_W;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [BUS_W-1:0]   main_data_q, main_data_d;
  logic [INDEX_W-1:0] main_index_q, main_index_d;
  logic               main_trig_q, main_trig_d;
  logic [BUS_W-1:0]   skid_data_q, skid_data_d;
  logic [INDEX_W-1:0] skid_index_q, skid_index_d;
  logic               skid_trig_q, skid_trig_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
  logic               accept_c, emit_c;

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_data    = main_data_q;
  assign out_index   = main_index_q;
  assign out_trigger = main_trig_q;
  assign stall_count = stall_q;

  assign accept_c = in_valid & in_ready_q;
  assign emit_c   = out_valid_q & out_ready;

  // Next-state and register-load selection
  always_comb begin
    state_d      = state_q;
    main_data_d  = main_data_q;
    main_index_d = main_index_q;
    main_trig_d  = main_trig_q;
    skid_data_d  = skid_data_q;
    skid_index_d = skid_index_q;
    skid_trig_d  = skid_trig_q;
    stall_d      = stall_q;

    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept_c) begin
            state_d      = ST_HALF;
            main_data_d  = in_data;
            main_index_d = in_index;
            main_trig_d  = in_trigger;
          end
        end
        ST_HALF: begin
          if (accept_c && emit_c) begin
            main_data_d  = in_data;
            main_index_d = in_index;
            main_trig_d  = in_trigger;
          end else if (accept_c) begin
            state_d      = ST_FULL;
            skid_data_d  = in_data;
            skid_index_d = in_index;
            skid_trig_d  = in_trigger;
          end else if (emit_c) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (emit_c) begin
            state_d      = ST_HALF;
            main_data_d  = skid_data_q;
            main_index_d = skid_index_q;
            main_trig_d  = skid_trig_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    // Stall counter saturates instead of wrapping
    if (out_valid_q && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end

    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      main_data_q  <= '0;
      main_index_q <= '0;
      main_trig_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_index_q <= '0;
      skid_trig_q  <= 1'b0;
      stall_q      <= '0;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      main_data_q  <= main_data_d;
      main_index_q <= main_index_d;
      main_trig_q  <= main_trig_d;
      skid_data_q  <= skid_data_d;
      skid_index_q <= skid_index_d;
      skid_trig_q  <= skid_trig_d;
      stall_q      <= stall_d;
      out_valid_q  <= out_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_sad_pipe_stage.sv
// Scoreboard bench for sad_pipe_stage: default instance plus 16x20 and 1x8 instances
// for lane-packing and trigger checks, all against a queue-based occupancy model.
module tb_sad_pipe_stage;

  localparam int unsigned BUS_W = 8 * 14;
  localparam int unsigned W_W   = 16 * 20;
  localparam int unsigned CW    = 320;

  typedef struct packed {
    logic [BUS_W-1:0] data;
    logic [15:0]      index;
    logic             trig;
  } ent_t;

  logic clk = 1'b0;
  logic rst, flush, in_valid, in_ready, in_trigger, out_valid, out_ready, out_trigger;
  logic [BUS_W-1:0] in_data, out_data;
  logic [15:0] in_index, out_index, stall_count;

  logic s_valid, s_trig;
  logic [15:0] s_index;
  logic [W_W-1:0] w_in_data, w_out_data;
  logic [7:0] n_in_data, n_out_data;
  logic w_in_ready, w_out_valid, w_out_trigger, n_in_ready, n_out_valid, n_out_trigger;
  logic [15:0] w_out_index, n_out_index, w_stall, n_stall;

  always #5 clk = ~clk;

  sad_pipe_stage u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_index(in_index), .in_trigger(in_trigger),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_trigger(out_trigger), .stall_count(stall_count));

  sad_pipe_stage #(.NUM_LANES(16), .DATA_W(20), .INDEX_W(16)) u_wide (
    .clk(clk), .rst(rst), .flush(1'b0), .in_valid(s_valid), .in_ready(w_in_ready),
    .in_data(w_in_data), .in_index(s_index), .in_trigger(s_trig),
    .out_valid(w_out_valid), .out_ready(1'b1), .out_data(w_out_data),
    .out_index(w_out_index), .out_trigger(w_out_trigger), .stall_count(w_stall));

  sad_pipe_stage #(.NUM_LANES(1), .DATA_W(8), .INDEX_W(16)) u_narrow (
    .clk(clk), .rst(rst), .flush(1'b0), .in_valid(s_valid), .in_ready(n_in_ready),
    .in_data(n_in_data), .in_index(s_index), .in_trigger(s_trig),
    .out_valid(n_out_valid), .out_ready(1'b1), .out_data(n_out_data),
    .out_index(n_out_index), .out_trigger(n_out_trigger), .stall_count(n_stall));

  int n_tests = 0;
  int n_fail  = 0;
  int occ_pre = 0;
  int w_cnt = 0;
  int n_cnt = 0;
  ent_t sb_q[$];
  logic [16:0] wq[$];
  logic [16:0] nq[$];
  logic [15:0] exp_stall = '0;
  bit acc_flag = 1'b0;
  bit post_rst = 1'b0;
  bit sat_req = 1'b0;
  bit fin_req = 1'b0;
  bit tmo = 1'b0;

  function automatic logic [BUS_W-1:0] lanes_m(input logic [15:0] idx);
    logic [BUS_W-1:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r[k*14 +: 14] = 14'(idx) + 14'(k);
    return r;
  endfunction

  function automatic logic [W_W-1:0] lanes_w(input logic [15:0] idx);
    logic [W_W-1:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[k*20 +: 20] = 20'(idx) + 20'(k);
    return r;
  endfunction

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model updates on the rising edge; all comparisons on the falling edge
  always begin
    @(posedge clk);
    acc_flag = 1'b0;
    post_rst = rst;
    if (rst) begin
      sb_q.delete();
      wq.delete();
      nq.delete();
      exp_stall = '0;
    end else begin
      if (flush) sb_q.delete();
      else if (in_valid && occ_pre < 2) begin
        sb_q.push_back({in_data, in_index, in_trigger});
        acc_flag = 1'b1;
      end
      if (s_valid) begin
        wq.push_back({s_trig, s_index});
        nq.push_back({s_trig, s_index});
      end
    end

    @(negedge clk);
    occ_pre = sb_q.size();
    if (post_rst) begin
      chk("rst_out_data", CW'(out_data), CW'(0));
      chk("rst_out_index", CW'(out_index), CW'(0));
      chk("rst_out_trigger", CW'(out_trigger), CW'(0));
    end
    chk("out_valid", CW'(out_valid), CW'(occ_pre > 0));
    chk("in_ready", CW'(in_ready), CW'(occ_pre < 2));
    chk("stall_count", CW'(stall_count), CW'(exp_stall));
    if (occ_pre > 0 && !out_ready && exp_stall != 16'hFFFF) exp_stall++;
    if (occ_pre > 0 && out_ready) begin
      ent_t e;
      e = sb_q.pop_front();
      chk("out_data", CW'(out_data), CW'(e.data));
      chk("out_index", CW'(out_index), CW'(e.index));
      chk("out_trigger", CW'(out_trigger), CW'(e.trig));
    end
    if (w_out_valid) begin
      chk("wide_has_entry", CW'(wq.size() != 0), CW'(1));
      if (wq.size() != 0) begin
        logic [16:0] e;
        e = wq.pop_front();
        w_cnt++;
        chk("wide_index", CW'(w_out_index), CW'(e[15:0]));
        chk("wide_trigger", CW'(w_out_trigger), CW'(e[16]));
        chk("wide_data", CW'(w_out_data), CW'(lanes_w(e[15:0])));
      end
    end
    if (n_out_valid) begin
      chk("narrow_has_entry", CW'(nq.size() != 0), CW'(1));
      if (nq.size() != 0) begin
        logic [16:0] e;
        e = nq.pop_front();
        n_cnt++;
        chk("narrow_index", CW'(n_out_index), CW'(e[15:0]));
        chk("narrow_trigger", CW'(n_out_trigger), CW'(e[16]));
        chk("narrow_data", CW'(n_out_data), CW'(e[7:0]));
      end
    end
    if (sat_req) chk("stall_saturated", CW'(stall_count), CW'(16'hFFFF));
    if (fin_req) begin
      chk("wide_count", CW'(w_cnt), CW'(16));
      chk("narrow_count", CW'(n_cnt), CW'(16));
      chk("handshake_timeout", CW'(tmo), CW'(0));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] idx);
    in_valid   = 1'b1;
    in_index   = idx;
    in_trigger = idx[0];
    in_data    = lanes_m(idx);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] tp;
    int guard;
    tp = 4'b1101;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_index = '0; in_trigger = 1'b0;
    in_data = '0; out_ready = 1'b1; s_valid = 1'b0; s_index = '0; s_trig = 1'b0;
    w_in_data = '0; n_in_data = '0;
    repeat (2) cyc();
    rst = 1'b0;
    cyc();

    // Streaming on all three instances, trigger pattern 1,0,1,1
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_index = 16'(i); in_trigger = tp[i % 4]; in_data = lanes_m(16'(i));
      s_valid = 1'b1; s_index = 16'(i); s_trig = tp[i % 4];
      w_in_data = lanes_w(16'(i)); n_in_data = 8'(i);
      cyc();
    end
    in_valid = 1'b0; s_valid = 1'b0;
    repeat (3) cyc();

    // Stall with skid: 1 in main, 2 in skid, 3 held upstream
    send(16'd1); cyc();
    out_ready = 1'b0; send(16'd2); cyc();
    send(16'd3); repeat (3) cyc();
    out_ready = 1'b1;
    guard = 0;
    do begin cyc(); guard++; end while (!acc_flag && guard < 20);
    if (!acc_flag) tmo = 1'b1;
    in_valid = 1'b0;
    repeat (3) cyc();

    // Flush while FULL with a new entry offered
    out_ready = 1'b0; send(16'd5); cyc();
    send(16'd6); cyc();
    send(16'd7); flush = 1'b1; cyc();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cyc();

    // Reset in FULL after stalling
    out_ready = 1'b0; send(16'd8); cyc();
    send(16'd9); cyc();
    guard = 0;
    while (exp_stall < 16'd10 && guard < 40) begin cyc(); guard++; end
    rst = 1'b1; cyc();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) cyc();

    // Randomized traffic with occasional flush
    repeat (400) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 40) == 0);
      in_index   = 16'($urandom);
      in_trigger = 1'($urandom);
      in_data    = BUS_W'({$urandom, $urandom, $urandom, $urandom});
      cyc();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) cyc();

    // Long stall to reach counter saturation
    out_ready = 1'b0; send(16'd42); cyc();
    in_valid = 1'b0;
    repeat (65540) cyc();
    sat_req = 1'b1;
    repeat (3) cyc();
    sat_req = 1'b0; out_ready = 1'b1;
    repeat (3) cyc();

    fin_req = 1'b1; cyc();
    fin_req = 1'b0; cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
